// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader that fills word-indexed instruction memory
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    // Largest legal word count, widened to the 16-bit header field.
    localparam logic [15:0] DEPTH_N = 16'(DEPTH);

    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       word_q, word_d;
    logic [1:0]        byte_q, byte_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic [15:0]       hdr_n;
    logic [15:0]       word_next;

    // The stream is only open while a frame is being parsed.
    always_comb begin
        in_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                   (state_q == S_DATA)   || (state_q == S_CSUM);
    end

    // Next-state, word packing and checksum accumulation.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        word_d    = word_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        accept    = in_valid && in_ready;
        hdr_n     = {n_q[15:8], in_data};
        word_next = word_q + 16'd1;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_HDR_HI;
                    n_d     = 16'd0;
                    word_d  = 16'd0;
                    byte_d  = 2'd0;
                    shift_d = 24'd0;
                    csum_d  = 8'd0;
                end
            end
            S_HDR_HI: begin
                if (accept) begin
                    n_d     = {in_data, 8'h00};
                    csum_d  = csum_q ^ in_data;
                    state_d = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (accept) begin
                    n_d    = hdr_n;
                    csum_d = csum_q ^ in_data;
                    if (hdr_n > DEPTH_N) begin
                        state_d = S_ERROR;
                    end else if (hdr_n == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d  = csum_q ^ in_data;
                    shift_d = {shift_q[15:0], in_data};
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        // Fourth byte completes a big-endian word; write it next cycle.
                        wr_en_d   = 1'b1;
                        wr_addr_d = word_q[ADDR_W-1:0];
                        wr_data_d = {shift_q, in_data};
                        word_d    = word_next;
                        if (word_next == n_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);
    end

    // State and registered outputs; reset abandons any load in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= 16'd0;
            word_q     <= 16'd0;
            byte_q     <= 2'd0;
            shift_q    <= 24'd0;
            csum_q     <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_q     <= word_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed frame tests for imem_loader
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    int          wr_total = 0;
    logic [39:0] wr_log [0:511];

    typedef struct {
        logic [95:0] bytes;
        int          len;
        int          nwr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        exp_done;
        logic        exp_err;
    } frame_t;

    frame_t frames [0:4];

    imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    // Write monitor: logs every imem write seen mid-cycle.
    always @(negedge clock) begin
        if (wr_en) begin
            if (wr_total < 512) wr_log[wr_total] = {wr_addr, wr_data};
            wr_total = wr_total + 1;
        end
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   t;
        logic rdy;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock); #1;
            t++;
        end while (!rdy && t < 50);
        in_valid = 1'b0;
        if (!rdy) begin
            n_checks++;
            $display("FAIL accept_timeout: byte %0h not taken, expected in_ready=1", b);
        end
    endtask

    task automatic check_frame(input string tag, input int base, input int idx);
        @(negedge clock);
        check({tag, "_nwr"}, 40'(wr_total - base), 40'(frames[idx].nwr));
        if (frames[idx].nwr >= 1)
            check({tag, "_w0"}, wr_log[base], {8'h00, frames[idx].w0});
        if (frames[idx].nwr >= 2)
            check({tag, "_w1"}, wr_log[base + 1], {8'h01, frames[idx].w1});
        check({tag, "_done"}, 40'(done), 40'(frames[idx].exp_done));
        check({tag, "_error"}, 40'(error), 40'(frames[idx].exp_err));
        check({tag, "_hold"}, 40'(cpu_hold), 40'(!frames[idx].exp_done));
        check({tag, "_ready"}, 40'(in_ready), 40'(0));
    endtask

    task automatic run_frame(input string tag, input int idx);
        int base;
        base = wr_total;
        pulse_start();
        for (int j = 0; j < frames[idx].len; j++)
            send_byte(frames[idx].bytes[95 - 8*j -: 8]);
        check_frame(tag, base, idx);
        @(posedge clock); #1;
    endtask

    initial begin
        int base;
        int k;

        frames[0] = '{96'h00021122334455667788_8A00, 11, 2, 32'h11223344, 32'h55667788, 1'b1, 1'b0};
        frames[1] = '{96'h00021122334455667788_FF00, 11, 2, 32'h11223344, 32'h55667788, 1'b0, 1'b1};
        frames[2] = '{96'h000000_000000000000000000,  3, 0, 32'h0,        32'h0,        1'b1, 1'b0};
        frames[3] = '{96'h000001_000000000000000000,  3, 0, 32'h0,        32'h0,        1'b0, 1'b1};
        frames[4] = '{96'h0001DEADBEEF23_0000000000,  7, 1, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        check("rst_ready", 40'(in_ready), 40'(0));
        check("rst_wr_en", 40'(wr_en), 40'(0));
        check("rst_wr_addr", 40'(wr_addr), 40'(0));
        check("rst_wr_data", 40'(wr_data), 40'(0));
        check("rst_done", 40'(done), 40'(0));
        check("rst_error", 40'(error), 40'(0));
        check("rst_hold", 40'(cpu_hold), 40'(1));
        @(posedge clock); #1;

        for (int i = 0; i < 5; i++) run_frame($sformatf("frame%0d", i), i);

        // Oversize header: error straight after the second byte.
        base = wr_total;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge clock);
        check("over_error", 40'(error), 40'(1));
        check("over_ready", 40'(in_ready), 40'(0));
        check("over_hold", 40'(cpu_hold), 40'(1));
        check("over_nwr", 40'(wr_total - base), 40'(0));
        @(posedge clock); #1;

        // Gaps between bytes and a start pulse while in DATA.
        base = wr_total;
        pulse_start();
        for (int j = 0; j < 11; j++) begin
            send_byte(frames[0].bytes[95 - 8*j -: 8]);
            k = $urandom_range(0, 3);
            repeat (k) begin @(posedge clock); #1; end
            if (j == 5) pulse_start();
        end
        check_frame("gap", base, 0);
        @(posedge clock); #1;

        // Reset after six payload bytes, then a clean reload.
        base = wr_total;
        pulse_start();
        for (int j = 0; j < 8; j++) send_byte(frames[0].bytes[95 - 8*j -: 8]);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("midrst_wr_en", 40'(wr_en), 40'(0));
        check("midrst_hold", 40'(cpu_hold), 40'(1));
        check("midrst_ready", 40'(in_ready), 40'(0));
        check("midrst_nwr", 40'(wr_total - base), 40'(1));
        @(posedge clock); #1;
        run_frame("reload", 0);

        // Full-depth load: N == DEPTH, payload byte i = i mod 256.
        base = wr_total;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 0; i < 1024; i++) send_byte(i[7:0]);
        send_byte(8'h01);
        @(negedge clock);
        check("full_nwr", 40'(wr_total - base), 40'(256));
        check("full_first", wr_log[base], {8'h00, 32'h00010203});
        check("full_last", wr_log[base + 255], {8'hFF, 32'hFCFDFEFF});
        check("full_done", 40'(done), 40'(1));
        check("full_hold", 40'(cpu_hold), 40'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
